theta_sequencer: RTL and testbench

THETA_SEQUENCER -- requirements
Module: theta_sequencer

---
 rtl/theta_sequencer_pkg.sv | 9 +
 rtl/theta_column_mix.sv | 26 ++
 rtl/theta_sequencer.sv | 87 ++++++++
 tb/tb_theta_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/theta_sequencer_pkg.sv
// theta_sequencer_pkg: shared FSM states, grid geometry and cell-to-memory-bit mapping
package theta_sequencer_pkg;
  typedef enum logic [2:0] {IDLE, LOAD, PARITY, DPREP, UPDATE, FINISH} state_t;
  localparam int GRID = 5;
  localparam int CELLS = 25;
  function automatic int mem_bit(input int i);
    return CELLS - 1 - i;
  endfunction
endpackage

// File: rtl/theta_column_mix.sv
// theta_column_mix: column parity accumulator C and neighbour mix D; ports: clk, rst (sync active-low), clr/en/calc controls, bit_in, column x, mix d
module theta_column_mix
  import theta_sequencer_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic            calc,
  input  logic            bit_in,
  input  logic [2:0]      x,
  output logic [GRID-1:0] d
);
  logic [GRID-1:0] c;
  always_ff @(posedge clk) begin
    if (!rst) begin
      c <= '0;
      d <= '0;
    end else begin
      if (clr) c <= '0;
      else if (en) c[x] <= c[x] ^ bit_in;
      // d[k] = c[k-1] ^ c[k+1] (mod GRID) expressed as two one-place rotations
      if (calc) d <= {c[GRID-2:0], c[GRID-1]} ^ {c[0], c[GRID-1:1]};
    end
  end
endmodule

// File: rtl/theta_sequencer.sv
// theta_sequencer: loads a 5x5 grid into memory, accumulates column parity, then xors each cell with its neighbour-column mix; ports: clk, rst (sync active-low), start, line_in, mem_out, mem, mem_init, mem_line, mem_index, mem_read, mem_write, mem_val, busy, done, result
module theta_sequencer
  import theta_sequencer_pkg::*;
#(
  parameter int SIZE    = 5,
  parameter int MEMSIZE = 25
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [MEMSIZE-1:0] line_in,
  input  logic               mem_out,
  input  logic [MEMSIZE-1:0] mem,
  output logic               mem_init,
  output logic [MEMSIZE-1:0] mem_line,
  output logic [SIZE-1:0]    mem_index,
  output logic               mem_read,
  output logic               mem_write,
  output logic               mem_val,
  output logic               busy,
  output logic               done,
  output logic [MEMSIZE-1:0] result
);
  state_t state, nxt;
  logic [MEMSIZE-1:0] line_q;
  logic [SIZE-1:0] idx;
  logic [2:0] x, y;
  logic [GRID-1:0] d;
  logic step, x_wrap, last;
  assign step = state == PARITY || state == UPDATE;
  assign x_wrap = x == 3'(GRID - 1);
  assign last = x_wrap && y == 3'(GRID - 1);
  // Counters wrap back to zero after the 25th cell, so each sweep starts clean
  always_ff @(posedge clk) begin
    if (!rst) begin
      state  <= IDLE;
      line_q <= '0;
      idx    <= '0;
      x      <= '0;
      y      <= '0;
      result <= '0;
    end else begin
      state <= nxt;
      if (state == IDLE && start) line_q <= line_in;
      if (step) begin
        idx <= last ? '0 : idx + SIZE'(1);
        x   <= x_wrap ? '0 : x + 3'd1;
        if (x_wrap) y <= y == 3'(GRID - 1) ? '0 : y + 3'd1;
      end
      if (state == FINISH)
        for (int i = 0; i < MEMSIZE; i++) result[i] <= mem[mem_bit(i)];
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = start ? LOAD : IDLE;
      LOAD:    nxt = PARITY;
      PARITY:  nxt = last ? DPREP : PARITY;
      DPREP:   nxt = UPDATE;
      UPDATE:  nxt = last ? FINISH : UPDATE;
      FINISH:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    mem_line = '0;
    for (int i = 0; i < MEMSIZE; i++) mem_line[mem_bit(i)] = line_q[i];
  end
  assign mem_init  = state == LOAD;
  assign mem_read  = step;
  assign mem_write = state == UPDATE;
  assign mem_index = step ? idx : '0;
  assign mem_val   = state == UPDATE && (mem_out ^ d[x]);
  assign busy      = state != IDLE && state != FINISH;
  assign done      = state == FINISH;
  theta_column_mix u_mix (
    .clk   (clk),
    .rst   (rst),
    .clr   (state == LOAD),
    .en    (state == PARITY),
    .calc  (state == DPREP),
    .bit_in(mem_out),
    .x     (x),
    .d     (d)
  );
endmodule

// File: tb/tb_theta_sequencer.sv
// tb_theta_sequencer: directed self-checking bench with a behavioural grid memory
module tb_theta_sequencer;
  logic clk, rst, start, mem_out, mem_init, mem_read, mem_write, mem_val, busy, done;
  logic [24:0] line_in, mem, mem_line, result;
  logic [4:0] mem_index;
  int checks = 0, errors = 0, cyc = 0, wr_total = 0, order_bad = 0, exp_idx = 0, base = 0, n = 0;

  theta_sequencer #(.SIZE(5), .MEMSIZE(25)) dut (
    .clk(clk), .rst(rst), .start(start), .line_in(line_in), .mem_out(mem_out), .mem(mem),
    .mem_init(mem_init), .mem_line(mem_line), .mem_index(mem_index), .mem_read(mem_read),
    .mem_write(mem_write), .mem_val(mem_val), .busy(busy), .done(done), .result(result)
  );

  initial clk = 0;
  always #5 clk = ~clk;

  assign mem_out = mem[24 - mem_index];

  // memory model plus write-order monitor: writes in a sweep must be 0,1,2,...
  always @(posedge clk) begin
    if (mem_init) mem <= mem_line;
    else if (mem_write) mem[24 - mem_index] <= mem_val;
    if (mem_write) begin
      if (int'(mem_index) != exp_idx) order_bad++;
      exp_idx = exp_idx + 1;
      wr_total++;
    end else exp_idx = 0;
    if (mem_init && mem_write) order_bad++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // called at a negedge; start is held for the accept cycle only (plus optional re-pulse)
  task automatic run(input logic [24:0] li, input logic [24:0] exp, input string tag,
                     input int repulse, input bit chain);
    line_in = li; start = 1; cyc = 1; base = wr_total;
    @(negedge clk); start = 0; cyc = 2;
    chk({tag, "_busy"}, busy, 1);
    chk({tag, "_init"}, mem_init, 1);
    while (!done && cyc < 200) begin
      @(negedge clk); cyc++;
      start = (cyc == repulse);
    end
    start = 0;
    chk({tag, "_latency"}, cyc, 54);
    chk({tag, "_busy_at_done"}, busy, 0);
    if (chain) start = 1;
    @(negedge clk);
    chk({tag, "_result"}, result, exp);
    chk({tag, "_done_pulse"}, done, 0);
    chk({tag, "_writes"}, wr_total - base, 25);
    chk({tag, "_order"}, order_bad, 0);
  endtask

  initial begin
    rst = 0; start = 0; line_in = '0; mem = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_result", result, 0);
    chk("rst_mem_ctl", {mem_init, mem_read, mem_write, mem_val}, 0);
    chk("rst_mem_index", mem_index, 0);
    chk("rst_mem_line", mem_line, 0);
    rst = 1;
    @(negedge clk);
    run(25'h0000000, 25'h0000000, "zero", 0, 0);
    run(25'h000001F, 25'h000001F, "row0", 0, 0);
    run(25'h0000001, 25'h1294A53, "cell0", 0, 0);
    run(25'h0000004, 25'h0A5294E, "repulse", 10, 0);
    chk("no_extra_done", done, 0);
    run(25'h1FFFFFF, 25'h1FFFFFF, "ones", 0, 1);
    // start held through the done cycle: state is IDLE here, accepted at the next edge
    chk("chain_idle_busy", busy, 0);
    line_in = 25'h0000001;
    @(negedge clk); start = 0; cyc = 2; base = wr_total;
    chk("chain_busy", busy, 1);
    chk("chain_init", mem_init, 1);
    while (!done && cyc < 200) begin @(negedge clk); cyc++; end
    chk("chain_latency", cyc, 54);
    @(negedge clk);
    chk("chain_result", result, 25'h1294A53);
    chk("chain_writes", wr_total - base, 25);
    // reset during UPDATE at cell 10
    line_in = 25'h000001F; start = 1;
    @(negedge clk); start = 0; n = 0;
    while (!(mem_write && mem_index == 5'd10) && n < 200) begin @(negedge clk); n++; end
    chk("abort_reach_i10", {31'b0, mem_write && mem_index == 5'd10}, 1);
    rst = 0;
    @(negedge clk);
    base = wr_total;
    chk("abort_busy", busy, 0);
    chk("abort_write", mem_write, 0);
    chk("abort_result", result, 0);
    chk("abort_done", done, 0);
    rst = 1;
    repeat (3) @(negedge clk);
    chk("abort_no_writes", wr_total - base, 0);
    chk("abort_idle_busy", busy, 0);
    run(25'h0000001, 25'h1294A53, "recover", 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
